// File: rtl/sseg_scan_driver_if.sv
// Bundle of display-side control and scan outputs for sseg_scan_driver.
// master: the display-value register side; slave: the scan driver.
interface sseg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [7:0]                cathode;
  logic [NUM_DIGITS-1:0]     anode;
  logic [IdxW-1:0]           digit_idx;
  logic                      frame_done;
  logic                      pending;

  modport master (
    output enable, load, value, dp_in,
    input  cathode, anode, digit_idx, frame_done, pending
  );

  modport slave (
    input  enable, load, value, dp_in,
    output cathode, anode, digit_idx, frame_done, pending
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with a double-buffered value.
// A load lands in the shadow buffer and is promoted to the active buffer only at a
// frame boundary, so a frame is never drawn from two different values.
// Optional build macro SSEG_LZ_BLANK_EN enables leading-zero blanking.
module sseg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter bit          ANODE_ACT_LO = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  sseg_scan_driver_if.slave bus
);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AnodeOff = ANODE_ACT_LO ? {NUM_DIGITS{1'b1}} : '0;

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;

  logic                    wrap, boundary, blank;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   onehot;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  assign wrap     = (cnt_q == LastCnt);
  assign boundary = bus.enable && wrap && (idx_q == LastIdx);
  assign cur_nib  = act_val_q[4*idx_q +: 4];
  assign onehot   = NUM_DIGITS'(1) << idx_q;

`ifdef SSEG_LZ_BLANK_EN
  logic [IdxW-1:0] lz_msd;

  // Highest nonzero digit of the active buffer; digit 0 is always shown.
  always_comb begin
    lz_msd = '0;
    for (int d = 1; d < NUM_DIGITS; d++) begin
      if (act_val_q[4*d +: 4] != 4'h0) lz_msd = IdxW'(d);
    end
  end
  assign blank = (idx_q > lz_msd);
`else
  assign blank = 1'b0;
`endif

  // Refresh counter and digit slot; both held at 0 while disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!bus.enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Shadow/active buffers; a load on the boundary cycle goes straight to active.
  always_comb begin
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    pending_d = pending_q;
    if (bus.load) begin
      sh_val_d = bus.value;
      sh_dp_d  = bus.dp_in;
    end
    if (bus.load && boundary) begin
      act_val_d = bus.value;
      act_dp_d  = bus.dp_in;
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      pending_d = 1'b0;
    end
  end

  // Pin drive for the current slot, registered one clock behind digit_idx.
  always_comb begin
    anode_d   = AnodeOff;
    cathode_d = 8'h00;
    if (bus.enable && !blank) begin
      cathode_d = {act_dp_q[idx_q], seg7(cur_nib)};
      anode_d   = ANODE_ACT_LO ? ~onehot : onehot;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      pending_q <= 1'b0;
      anode_q   <= AnodeOff;
      cathode_q <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign bus.cathode    = cathode_q;
  assign bus.anode      = anode_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = boundary;
  assign bus.pending    = pending_q;
endmodule
